hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / stall / flush / halt controller for a 5-stage in-order pipe.
// Optional macro HAZARD_FORWARD_EN: only load-use stalls (EX/MEM forwarding present).
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic        id_rs_vld,
  input  logic [2:0]  id_rt,
  input  logic        id_rt_vld,
  input  logic [2:0]  idex_rd,
  input  logic        idex_regwrt,
  input  logic        idex_memrd,
  input  logic [2:0]  exmem_rd,
  input  logic        exmem_regwrt,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  input  logic        halt_id,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEMSTALL, DRAIN, HALTED} state_e;

  state_e      state_q, state_d;
  logic        saved_q, saved_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;

  logic idex_match, exmem_match, hazard;
  logic in_drain;

  assign idex_match  = (id_rs_vld && (id_rs == idex_rd))  || (id_rt_vld && (id_rt == idex_rd));
  assign exmem_match = (id_rs_vld && (id_rs == exmem_rd)) || (id_rt_vld && (id_rt == exmem_rd));

`ifdef HAZARD_FORWARD_EN
  assign hazard = idex_regwrt && idex_memrd && idex_match;
`else
  // Write-before-read register file means MEM_WB never needs a stall.
  assign hazard = (idex_regwrt && idex_match) || (exmem_regwrt && exmem_match);
`endif

  // A freeze behaves like the state it interrupted (saved_q: 1 = DRAIN).
  assign in_drain = (state_q == DRAIN) || ((state_q == MEMSTALL) && saved_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      saved_q <= 1'b0;
      cnt_q   <= 2'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    if (state_q != HALTED) begin
      if (mem_busy) begin
        state_d = MEMSTALL;
        saved_d = in_drain;
      end else if (in_drain) begin
        cnt_d   = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd1) ? HALTED : DRAIN;
      end else begin
        state_d = RUN;
        if (!ex_redirect && !hazard && halt_id) begin
          state_d = DRAIN;
          cnt_d   = 2'd3;
        end
      end
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      if (state_q == HALTED) begin
        halted = 1'b1;
      end else if (!mem_busy) begin
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        if (in_drain || (!ex_redirect && hazard)) begin
          idex_bubble = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q != HALTED) && !pc_en && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: driver queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Control vector order: pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb, halted.
  localparam logic [7:0] C_RUN   = 8'hD6;
  localparam logic [7:0] C_REDIR = 8'hFE;
  localparam logic [7:0] C_STALL = 8'h1E;
  localparam logic [7:0] C_FROZE = 8'h00;
  localparam logic [7:0] C_HALT  = 8'h01;
  localparam logic [7:0] C_RAW   = FWD ? C_RUN : C_STALL;

  typedef struct packed {
    logic [2:0] rs;
    logic       rsVld;
    logic [2:0] rt;
    logic       rtVld;
    logic [2:0] idexRd;
    logic       idexRegwrt;
    logic       idexMemrd;
    logic [2:0] exmemRd;
    logic       exmemRegwrt;
    logic       redirect;
    logic       busy;
    logic       haltId;
  } stim_t;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [15:0] stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  idRs = '0, idRt = '0, idexRd = '0, exmemRd = '0;
  logic        idRsVld = 1'b0, idRtVld = 1'b0, idexRegwrt = 1'b0, idexMemrd = 1'b0;
  logic        exmemRegwrt = 1'b0, exRedirect = 1'b0, memBusy = 1'b0, haltId = 1'b0;
  logic        pcEn, ifidEn, ifidFlush, idexEn, idexBubble, exmemEn, memwbEn, halted;
  logic [15:0] stallCycles;

  stim_t nxt = '0;
  exp_t  sb[$];
  int    checkCount = 0;
  int    passCount  = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (idRs),
    .id_rs_vld    (idRsVld),
    .id_rt        (idRt),
    .id_rt_vld    (idRtVld),
    .idex_rd      (idexRd),
    .idex_regwrt  (idexRegwrt),
    .idex_memrd   (idexMemrd),
    .exmem_rd     (exmemRd),
    .exmem_regwrt (exmemRegwrt),
    .ex_redirect  (exRedirect),
    .mem_busy     (memBusy),
    .halt_id      (haltId),
    .pc_en        (pcEn),
    .ifid_en      (ifidEn),
    .ifid_flush   (ifidFlush),
    .idex_en      (idexEn),
    .idex_bubble  (idexBubble),
    .exmem_en     (exmemEn),
    .memwb_en     (memwbEn),
    .halted       (halted),
    .stall_cycles (stallCycles)
  );

  always #5 clk = ~clk;

  task automatic driveInputs(input stim_t s);
    idRs        = s.rs;
    idRsVld     = s.rsVld;
    idRt        = s.rt;
    idRtVld     = s.rtVld;
    idexRd      = s.idexRd;
    idexRegwrt  = s.idexRegwrt;
    idexMemrd   = s.idexMemrd;
    exmemRd     = s.exmemRd;
    exmemRegwrt = s.exmemRegwrt;
    exRedirect  = s.redirect;
    memBusy     = s.busy;
    haltId      = s.haltId;
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] ctl, input logic [15:0] stall);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    driveInputs(nxt);
    e.name  = name;
    e.ctl   = ctl;
    e.stall = stall;
    sb.push_back(e);
    nxt = '0;
  endtask

  task automatic doReset(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    driveInputs('0);
    e.name  = name;
    e.ctl   = C_FROZE;
    e.stall = 16'd0;
    sb.push_back(e);
  endtask

  task automatic setLoadUse();
    nxt.idexMemrd  = 1'b1;
    nxt.idexRegwrt = 1'b1;
    nxt.idexRd     = 3'd3;
    nxt.rs         = 3'd3;
    nxt.rsVld      = 1'b1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {pcEn, ifidEn, ifidFlush, idexEn, idexBubble, exmemEn, memwbEn, halted};
    checkCount++;
    if (act === e.ctl) passCount++;
    else $display("[TB] FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
    checkCount++;
    if (stallCycles === e.stall) passCount++;
    else $display("[TB] FAIL %s stall_cycles: got %h expected %h", e.name, stallCycles, e.stall);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    doReset("reset");
    applyStimulus("idle", C_RUN, 16'd0);
    setLoadUse();
    applyStimulus("loadUse", C_STALL, 16'd0);
    applyStimulus("afterLoadUse", C_RUN, 16'd1);
    nxt.idexRegwrt = 1'b1; nxt.idexRd = 3'd5; nxt.rt = 3'd5; nxt.rtVld = 1'b1;
    applyStimulus("aluRaw", C_RAW, 16'd1);
    nxt.idexRegwrt = 1'b1; nxt.idexRd = 3'd5; nxt.rt = 3'd5; nxt.rtVld = 1'b0;
    applyStimulus("aluRawNoVld", C_RUN, FWD ? 16'd1 : 16'd2);
    nxt.exmemRegwrt = 1'b1; nxt.exmemRd = 3'd2; nxt.rs = 3'd2; nxt.rsVld = 1'b1;
    applyStimulus("exmemRaw", C_RAW, FWD ? 16'd1 : 16'd2);

    doReset("reset2");
    setLoadUse(); nxt.idexRd = 3'd4;
    applyStimulus("noMatch", C_RUN, 16'd0);
    setLoadUse(); nxt.idexRegwrt = 1'b0;
    applyStimulus("noRegwrt", C_RUN, 16'd0);
    setLoadUse(); nxt.busy = 1'b1;
    applyStimulus("busyRun", C_FROZE, 16'd0);
    setLoadUse();
    applyStimulus("releaseRunHaz", C_STALL, 16'd1);
    applyStimulus("afterRelease", C_RUN, 16'd2);

    setLoadUse(); nxt.redirect = 1'b1; nxt.haltId = 1'b1;
    applyStimulus("redirAll", C_REDIR, 16'd2);
    applyStimulus("afterRedir", C_RUN, 16'd2);
    nxt.haltId = 1'b1;
    applyStimulus("halt", C_RUN, 16'd2);
    nxt.redirect = 1'b1;
    applyStimulus("drain1", C_STALL, 16'd2);
    for (int i = 0; i < 4; i++) begin
      nxt.busy = 1'b1;
      applyStimulus("busyDrain", C_FROZE, 16'(3 + i));
    end
    applyStimulus("drain2", C_STALL, 16'd7);
    applyStimulus("drain3", C_STALL, 16'd8);
    applyStimulus("halted", C_HALT, 16'd9);
    setLoadUse(); nxt.redirect = 1'b1; nxt.busy = 1'b1; nxt.haltId = 1'b1;
    applyStimulus("haltedIgnore", C_HALT, 16'd9);

    doReset("resetHalted");
    applyStimulus("runAfterReset", C_RUN, 16'd0);
    nxt.haltId = 1'b1;
    applyStimulus("halt2", C_RUN, 16'd0);
    applyStimulus("drainA", C_STALL, 16'd0);
    doReset("resetMidDrain");
    applyStimulus("postReset", C_RUN, 16'd0);
    applyStimulus("postReset2", C_RUN, 16'd0);

    nxt.busy = 1'b1;
    applyStimulus("busyFirst", C_FROZE, 16'd0);
    repeat (65536) @(posedge clk);
    nxt.busy = 1'b1;
    applyStimulus("busySat", C_FROZE, 16'hFFFF);
    nxt.haltId = 1'b1;
    applyStimulus("halt3", C_RUN, 16'hFFFF);
    for (int i = 0; i < 3; i++) applyStimulus("drainSat", C_STALL, 16'hFFFF);
    applyStimulus("haltedSat", C_HALT, 16'hFFFF);
    doReset("resetSat");
    applyStimulus("releaseRun", C_RUN, 16'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
